// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants, frame-buffer address
// field widths and the raster decode struct used by the VGA frame reader.
package vga_timing_pkg;

  // 640x480@60 timing, all horizontal values in pixels, vertical in lines.
  localparam int CLK_DIV_DEF       = 4;
  localparam int H_VIS_DEF         = 640;
  localparam int H_FP_DEF          = 16;
  localparam int H_SYNC_DEF        = 96;
  localparam int H_BP_DEF          = 48;
  localparam int V_VIS_DEF         = 480;
  localparam int V_FP_DEF          = 10;
  localparam int V_SYNC_DEF        = 2;
  localparam int V_BP_DEF          = 33;
  localparam int H_TOTAL           = 800;
  localparam int V_TOTAL           = 525;
  localparam int COLOUR_PERIOD_DEF = 60;

  // Raster counter width and frame-buffer address fields.
  localparam int CNT_W     = 10;
  localparam int FB_H_W    = 9;
  localparam int FB_V_W    = 8;
  localparam int FB_ADDR_W = FB_V_W + FB_H_W;

  // Raster decode of one (h, v) position; sync levels are active low.
  typedef struct packed {
    logic hs;
    logic vs;
    logic visible;
  } sync_t;

  // 2x2 doubling: drop bit 0 of each counter to form {V_ADDR, H_ADDR}.
  function automatic logic [FB_ADDR_W-1:0] fb_addr_of(input logic [CNT_W-1:0] h,
                                                      input logic [CNT_W-1:0] v);
    return {v[FB_V_W:1], h[FB_H_W:1]};
  endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-tick divider, raster counters and the raw sync /
// visible decode for the current position. FRAME_START is the tick at (0,0).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             tick,
  output logic             frame_start,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output sync_t            sync_raw
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_C   = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C   = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  // The tick is the last divider phase; all raster state moves on that edge.
  assign tick        = (div_q == DIV_LAST);
  assign frame_start = tick && (h_q == '0) && (v_q == '0);
  assign hcount      = h_q;
  assign vcount      = v_q;

  // Next divider phase and raster position; vcount steps when hcount wraps.
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Divider and counter state; reset restarts the frame at (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Raw decode of the current position, before the one-tick output delay.
  always_comb begin
    sync_raw.visible = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    sync_raw.hs      = !((h_q >= H_SYNC_LO) && (h_q <= H_SYNC_HI));
    sync_raw.vs      = !((v_q >= V_SYNC_LO) && (v_q <= V_SYNC_HI));
  end

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: reads a 320x240x1bpp frame buffer with 2x2 doubling and
// drives 640x480@60 VGA. Optional feature macro COLOUR_CYCLE_EN adds a
// foreground colour offset that steps once every COLOUR_PERIOD frames.
//
// Timing per pixel: on tick edge E the address for (h,v) is registered, the
// buffer returns data at E+1, the data is sampled at E+2, and on the next tick
// edge colour and both syncs update together. Output latency is one tick.
module vga_frame_reader
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV       = CLK_DIV_DEF,
  parameter int H_VIS         = H_VIS_DEF,
  parameter int H_FP          = H_FP_DEF,
  parameter int H_SYNC        = H_SYNC_DEF,
  parameter int H_BP          = H_BP_DEF,
  parameter int V_VIS         = V_VIS_DEF,
  parameter int V_FP          = V_FP_DEF,
  parameter int V_SYNC        = V_SYNC_DEF,
  parameter int V_BP          = V_BP_DEF,
  parameter int COLOUR_PERIOD = COLOUR_PERIOD_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [15:0]          COLOUR_IN,
  input  logic                 FB_DATA,
  output logic [FB_ADDR_W-1:0] FB_ADDR,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic [7:0]           VGA_COLOUR,
  output logic                 FRAME_START
);

  // The data sample slot (tick + 2) must land before the next tick, the
  // raster must fit the 10-bit counters and the period the 8-bit frame counter.
  if (CLK_DIV < 3 || COLOUR_PERIOD < 1 || COLOUR_PERIOD > 256 ||
      (H_VIS + H_FP + H_SYNC + H_BP) > 1024 ||
      (V_VIS + V_FP + V_SYNC + V_BP) > 1024) begin : g_bad_params
    $error("vga_frame_reader: unsupported parameter set");
  end

  logic             tick;
  logic             frame_start;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  sync_t            sync_raw;

  vga_sync_gen #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_sync (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .tick        (tick),
    .frame_start (frame_start),
    .hcount      (hcount),
    .vcount      (vcount),
    .sync_raw    (sync_raw)
  );

  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  sync_t                sync_d1_q, sync_d1_d;
  logic [1:0]           tick_dly_q, tick_dly_d;
  logic                 data_q, data_d;
  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;
  logic [7:0]           colour_q, colour_d;
  logic [15:0]          latch_q, latch_d;
  logic [7:0]           fg_next;

`ifdef COLOUR_CYCLE_EN
  localparam logic [7:0] PERIOD_LAST = 8'(COLOUR_PERIOD - 1);

  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] offset_q, offset_d;

  // Count FRAME_START pulses; each wrap of the frame counter bumps the offset.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    offset_d    = offset_q;
    if (frame_start) begin
      if (frame_cnt_q == PERIOD_LAST) begin
        frame_cnt_d = '0;
        offset_d    = offset_q + 8'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // Frame counter and offset state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_cnt_q <= '0;
      offset_q    <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      offset_q    <= offset_d;
    end
  end

  // A frame uses the offset as it stood before its own FRAME_START updates it.
  assign fg_next = COLOUR_IN[15:8] + offset_q;
`else
  assign fg_next = COLOUR_IN[15:8];
`endif

  // Address, pipeline and colour mapping, all stepped by the pixel tick.
  always_comb begin
    fb_addr_d  = fb_addr_q;
    sync_d1_d  = sync_d1_q;
    tick_dly_d = {tick_dly_q[0], tick};
    data_d     = data_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    colour_d   = colour_q;
    latch_d    = latch_q;
    if (tick) begin
      fb_addr_d = sync_raw.visible ? fb_addr_of(hcount, vcount) : '0;
      sync_d1_d = sync_raw;
      hs_d      = sync_d1_q.hs;
      vs_d      = sync_d1_q.vs;
      if (sync_d1_q.visible) begin
        colour_d = data_q ? latch_q[15:8] : latch_q[7:0];
      end else begin
        colour_d = 8'h00;
      end
    end
    if (tick_dly_q[1]) begin
      data_d = FB_DATA;
    end
    // Colours change only at frame boundaries, so a frame never tears.
    if (frame_start) begin
      latch_d = {fg_next, COLOUR_IN[7:0]};
    end
  end

  // Pipeline state; reset blanks the output and releases both syncs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fb_addr_q  <= '0;
      sync_d1_q  <= '{hs: 1'b1, vs: 1'b1, visible: 1'b0};
      tick_dly_q <= '0;
      data_q     <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      colour_q   <= 8'h00;
      latch_q    <= 16'h0000;
    end else begin
      fb_addr_q  <= fb_addr_d;
      sync_d1_q  <= sync_d1_d;
      tick_dly_q <= tick_dly_d;
      data_q     <= data_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      colour_q   <= colour_d;
      latch_q    <= latch_d;
    end
  end

  assign FB_ADDR     = fb_addr_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_COLOUR  = colour_q;
  assign FRAME_START = frame_start;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: two instances share one clock. "s_" is a reduced
// raster (24x12) run over many frames with random buffer contents, random
// colours and a mid-frame reset; "f_" is the full 640x480 raster run over its
// first five lines with a buffer that holds a 1 only at address 514.
module tb_vga_frame_reader;

  localparam int DIV = 4;

  localparam int S_HV = 16, S_HF = 2, S_HS = 4, S_HB = 2;
  localparam int S_VV = 8,  S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FT = S_HT * S_VT;
  localparam int S_PERIOD = 2;

  localparam int F_HV = 640, F_HF = 16, F_HS = 96;
  localparam int F_VV = 480, F_VF = 10, F_VS = 2;
  localparam int F_HT = 800, F_VT = 525;
  localparam int F_FT = F_HT * F_VT;
  localparam logic [7:0] F_FG = 8'hE0;
  localparam logic [7:0] F_BG = 8'h1C;

  // ---------------- clock / reset ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        s_rst_n, s_fb_data, s_hs, s_vs, s_frame_start;
  logic [15:0] s_colour_in;
  logic [16:0] s_fb_addr;
  logic [7:0]  s_colour;
  logic        f_rst_n, f_fb_data, f_hs, f_vs, f_frame_start;
  logic [15:0] f_colour_in;
  logic [16:0] f_fb_addr;
  logic [7:0]  f_colour;

  vga_frame_reader #(
    .CLK_DIV (DIV),
    .H_VIS (S_HV), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_VIS (S_VV), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
    .COLOUR_PERIOD (S_PERIOD)
  ) dut (
    .CLK         (clk),
    .RESET_N     (s_rst_n),
    .COLOUR_IN   (s_colour_in),
    .FB_DATA     (s_fb_data),
    .FB_ADDR     (s_fb_addr),
    .VGA_HS      (s_hs),
    .VGA_VS      (s_vs),
    .VGA_COLOUR  (s_colour),
    .FRAME_START (s_frame_start)
  );

  vga_frame_reader dut_full (
    .CLK         (clk),
    .RESET_N     (f_rst_n),
    .COLOUR_IN   (f_colour_in),
    .FB_DATA     (f_fb_data),
    .FB_ADDR     (f_fb_addr),
    .VGA_HS      (f_hs),
    .VGA_VS      (f_vs),
    .VGA_COLOUR  (f_colour),
    .FRAME_START (f_frame_start)
  );

  // Frame-buffer models: one-CLK read latency.
  logic s_mem [0:4095];
  always @(posedge clk) s_fb_data <= s_mem[s_fb_addr[11:0]];
  always @(posedge clk) f_fb_data <= (f_fb_addr == 17'd514);

  // CLK edges since each reset release.
  int s_cyc, f_cyc;
  always @(posedge clk or negedge s_rst_n)
    if (!s_rst_n) s_cyc <= 0; else s_cyc <= s_cyc + 1;
  always @(posedge clk or negedge f_rst_n)
    if (!f_rst_n) f_cyc <= 0; else f_cyc <= f_cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [16:0] addr_of(input int h, input int v, input int hv, input int vv);
    if (h < hv && v < vv) return 17'((v / 2) * 512 + h / 2);
    return 17'd0;
  endfunction

  // Expected {VS, HS, COLOUR} for position (h, v).
  function automatic logic [9:0] px_of(input int h, input int v,
                                       input int hv, input int hf, input int hsw,
                                       input int vv, input int vf, input int vsw,
                                       input logic d, input logic [7:0] fg, input logic [7:0] bg);
    logic vis, hs, vs;
    logic [7:0] c;
    vis = (h < hv) && (v < vv);
    hs  = !(h >= hv + hf && h < hv + hf + hsw);
    vs  = !(v >= vv + vf && v < vv + vf + vsw);
    c   = !vis ? 8'h00 : (d ? fg : bg);
    return {vs, hs, c};
  endfunction

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [9:0] s_exp_q[$];
  logic [9:0] f_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Reduced raster: push the expected pixel for every tick, track the colour
  // in force at each frame start, and change COLOUR_IN mid-frame.
  logic [15:0] s_frame_col;
  initial begin : s_stim
    int k, h, v;
    logic [16:0] a;
    logic [7:0] off;
    forever begin
      @(negedge clk);
      if (s_rst_n && s_cyc >= DIV && s_cyc % DIV == 0) begin
        k = (s_cyc - DIV) / DIV;
        h = k % S_HT;
        v = (k / S_HT) % S_VT;
        if (h == 0 && v == 0) s_frame_col = s_colour_in;
`ifdef COLOUR_CYCLE_EN
        off = 8'(((k / S_FT) / S_PERIOD) % 256);
`else
        off = 8'd0;
`endif
        a = addr_of(h, v, S_HV, S_VV);
        s_exp_q.push_back(px_of(h, v, S_HV, S_HF, S_HS, S_VV, S_VF, S_VS,
                                s_mem[a[11:0]], s_frame_col[15:8] + off, s_frame_col[7:0]));
        if (h == S_HV / 2 && v == S_VV / 2) s_colour_in = 16'($urandom);
      end
    end
  end

  // Full raster: expected pixels for the fixed E0/1C colours.
  initial begin : f_stim
    int k, h, v;
    logic [16:0] a;
    forever begin
      @(negedge clk);
      if (f_rst_n && f_cyc >= DIV && f_cyc % DIV == 0) begin
        k = (f_cyc - DIV) / DIV;
        h = k % F_HT;
        v = (k / F_HT) % F_VT;
        a = addr_of(h, v, F_HV, F_VV);
        f_exp_q.push_back(px_of(h, v, F_HV, F_HF, F_HS, F_VV, F_VF, F_VS,
                                (a == 17'd514), F_FG, F_BG));
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin : s_mon
    int k;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (s_rst_n) begin
        check("s_frame_start", 32'(s_frame_start),
              32'((s_cyc % DIV == DIV - 1) && ((s_cyc / DIV) % S_FT == 0)));
        if (s_cyc >= DIV && s_cyc % DIV == 0) begin
          k = (s_cyc - DIV) / DIV;
          check("s_fb_addr", 32'(s_fb_addr), 32'(addr_of(k % S_HT, (k / S_HT) % S_VT, S_HV, S_VV)));
        end
        if (s_cyc >= 2 * DIV && s_cyc % DIV == 0) begin
          tests_run++;
          if (s_exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL s_pixel at %0t: got output with no expected entry queued", $time);
          end else begin
            e = s_exp_q.pop_front();
            tests_run--;
            check("s_pixel{vs,hs,colour}", 32'({s_vs, s_hs, s_colour}), 32'(e));
          end
        end
      end
    end
  end

  initial begin : f_mon
    int k;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (f_rst_n) begin
        check("f_frame_start", 32'(f_frame_start),
              32'((f_cyc % DIV == DIV - 1) && ((f_cyc / DIV) % F_FT == 0)));
        if (f_cyc >= DIV && f_cyc % DIV == 0) begin
          k = (f_cyc - DIV) / DIV;
          check("f_fb_addr", 32'(f_fb_addr), 32'(addr_of(k % F_HT, (k / F_HT) % F_VT, F_HV, F_VV)));
        end
        if (f_cyc >= 2 * DIV && f_cyc % DIV == 0) begin
          tests_run++;
          if (f_exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL f_pixel at %0t: got output with no expected entry queued", $time);
          end else begin
            e = f_exp_q.pop_front();
            tests_run--;
            check("f_pixel{vs,hs,colour}", 32'({f_vs, f_hs, f_colour}), 32'(e));
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int target;
    s_rst_n     = 1'b0;
    f_rst_n     = 1'b0;
    s_colour_in = 16'($urandom);
    f_colour_in = {F_FG, F_BG};
    s_frame_col = 16'h0000;
    for (int i = 0; i < 4096; i++) s_mem[i] = 1'($urandom);

    // Reset held for 20 CLK: idle output levels on both instances.
    repeat (20) @(negedge clk);
    #1;
    check("rst_s_hs", 32'(s_hs), 32'd1);
    check("rst_s_vs", 32'(s_vs), 32'd1);
    check("rst_s_colour", 32'(s_colour), 32'd0);
    check("rst_s_fb_addr", 32'(s_fb_addr), 32'd0);
    check("rst_s_frame_start", 32'(s_frame_start), 32'd0);
    check("rst_f_hs", 32'(f_hs), 32'd1);
    check("rst_f_vs", 32'(f_vs), 32'd1);
    check("rst_f_colour", 32'(f_colour), 32'd0);
    check("rst_f_fb_addr", 32'(f_fb_addr), 32'd0);
    check("rst_f_frame_start", 32'(f_frame_start), 32'd0);
    s_rst_n = 1'b1;
    f_rst_n = 1'b1;

    // Seven reduced frames, then reset inside line 5 while HS is low.
    target = 2 * DIV + DIV * (7 * S_FT + 5 * S_HT + 19) + 1;
    for (int i = 0; i < 20000 && s_cyc < target; i++) @(negedge clk);
    #1;
    s_rst_n = 1'b0;
    s_exp_q.delete();
    #1;
    check("midrst_s_hs", 32'(s_hs), 32'd1);
    check("midrst_s_vs", 32'(s_vs), 32'd1);
    check("midrst_s_colour", 32'(s_colour), 32'd0);
    check("midrst_s_fb_addr", 32'(s_fb_addr), 32'd0);
    check("midrst_s_frame_start", 32'(s_frame_start), 32'd0);
    for (int i = 0; i < 4096; i++) s_mem[i] = 1'($urandom);
    s_colour_in = 16'($urandom);
    repeat (7) @(negedge clk);
    #1;
    s_rst_n = 1'b1;

    // Three more reduced frames from the restarted raster.
    repeat (3 * S_FT * DIV + 40) @(negedge clk);

    // Let the full raster cover its first five lines.
    target = 2 * DIV + DIV * 5 * F_HT;
    for (int i = 0; i < 40000 && f_cyc < target; i++) @(negedge clk);
    if (f_cyc < target) begin
      tests_run++;
      tests_failed++;
      $display("FAIL f_run_length: reached %0d CLK, needed %0d", f_cyc, target);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
